noc_inject_port: RTL

Credit-controlled injection stage between a node's processing element and the router's local input port (port 5). It accepts flits from the PE over a valid/ready handshake and buffers them in a small FIFO. It forwards them to the router only while the router's local input buffer has space, tracking that space with a credit counter fed by the router's local credit-return pulse. It sits directly upstream of the router local port (`in5`/`vi5`, credit from `co5`) and turns the PE's bursty output into a flow that never overflows the router.

---
 rtl/noc_pkg.sv | 11 +
 rtl/flit_fifo.sv | 60 ++++++
 rtl/noc_inject_port.sv | 90 +++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, router local-buffer depth and the flit type
// used by the router, the PE and the injection port.
package noc_pkg;

    localparam int unsigned FLIT_W         = 20;
    localparam int unsigned ROUTER_CREDITS = 4;
    localparam int unsigned INJ_DEPTH      = 4;

    typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO with occupancy count; push when full and pop when empty are ignored.
module flit_fifo #(
    parameter int unsigned FLIT_W = 20,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         RST,
    input  logic                         push,
    input  logic                         pop,
    input  logic [FLIT_W-1:0]            din,
    output logic [FLIT_W-1:0]            dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full    = (cnt_q == DEPTH_C);
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_q];
    assign count   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_q] <= din;
                wr_ptr_q      <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/noc_inject_port.sv
// Credit-controlled injection stage from a PE into the router local port; buffers PE flits
// and forwards them only while the router's local input buffer has credit.
module noc_inject_port import noc_pkg::*; #(
    parameter int unsigned FLIT_W         = noc_pkg::FLIT_W,
    parameter int unsigned DEPTH          = noc_pkg::INJ_DEPTH,
    parameter int unsigned ROUTER_CREDITS = noc_pkg::ROUTER_CREDITS
) (
    input  logic                                clk,
    input  logic                                RST,
    input  logic [FLIT_W-1:0]                   pe_flit,
    input  logic                                pe_valid,
    output logic                                pe_ready,
    output logic [FLIT_W-1:0]                   dataout,
    output logic                                out_valid,
    input  logic                                ci,
    output logic [$clog2(ROUTER_CREDITS+1)-1:0] credit_cnt,
    output logic [$clog2(DEPTH+1)-1:0]          fifo_cnt,
    output logic                                credit_err
);

    localparam int unsigned CRD_W = $clog2(ROUTER_CREDITS + 1);
    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(ROUTER_CREDITS);

    logic              fifo_full, fifo_empty;
    logic              push, issue;
    logic [FLIT_W-1:0] head;

    logic [CRD_W-1:0]  credit_q, credit_d;
    logic              err_q, err_d;
    logic              valid_q;
    logic [FLIT_W-1:0] data_q;

    // Ready and issue depend only on registered state (plus reset), never on ci or pe_valid.
    assign pe_ready = !RST && !fifo_full;
    assign push     = pe_valid && pe_ready;
    assign issue    = !fifo_empty && (credit_q != '0);

    flit_fifo #(
        .FLIT_W(FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk  (clk),
        .RST  (RST),
        .push (push),
        .pop  (issue),
        .din  (pe_flit),
        .dout (head),
        .count(fifo_cnt),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        unique case ({issue, ci})
            2'b10: credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == CRD_MAX) begin
                    err_d = 1'b1;
                end else begin
                    credit_d = credit_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            credit_q <= CRD_MAX;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            credit_q <= credit_d;
            err_q    <= err_d;
            valid_q  <= issue;
            if (issue) begin
                data_q <= head;
            end
        end
    end

    assign dataout    = data_q;
    assign out_valid  = valid_q;
    assign credit_cnt = credit_q;
    assign credit_err = err_q;

endmodule
